buf_alloc_ctrl: RTL and testbench
=================================

Name: buf_alloc_ctrl

Overview:
- Requester side of the 4-entry LFU replacement interface: a 4-entry tag directory that resolves lookup requests to a buffer number.
- On a hit it reports the referenced buffer on ref_buf_numbr.
- On a miss with all entries valid it pulses new_buf_req, takes the victim from buf_num_replc, installs the tag there and responds.
- Sits between the client request port and the LFU selector.

Parameters:
- TAG_W, 8, width of lookup tag.
- CNT_W, 16, width of saturating hit/miss statistic counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_vld  in  1  lookup request valid.
- req_tag  in  TAG_W  lookup tag.
- req_rdy  out  1  request accepted when req_vld&req_rdy.
- flush  in  1  invalidate all entries (honoured in IDLE only).
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response consumed when rsp_vld&rsp_rdy.
- rsp_hit  out  1  1=hit, 0=miss (installed).
- rsp_buf  out  2  buffer number hit or installed.
- new_buf_req  out  1  request victim from LFU selector.
- ref_buf_numbr  out  2  most recently referenced buffer, to LFU selector.
- buf_num_replc  in  2  victim from LFU selector, registered by it on the edge where new_buf_req=1.
- hit_cnt  out  CNT_W  saturating hit count.
- miss_cnt  out  CNT_W  saturating miss count.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all valid bits=0; tags=0.
  - rsp_vld=0, rsp_hit=0, rsp_buf=0, new_buf_req=0, ref_buf_numbr=0, hit_cnt=0, miss_cnt=0.
  - Reset mid-operation aborts any transaction; no response is produced.
- States: IDLE, CMP, REPL, WAIT, RSP. All outputs are registered or Moore.
- IDLE:
  - req_rdy = ~flush.
  - flush=1: clear all valid bits, stay in IDLE.
  - Else on req_vld: capture req_tag, go to CMP.
- CMP: compare the captured tag against valid entries.
  - Hit: rsp_hit=1, rsp_buf=index, ref_buf_numbr<=index, hit_cnt++, go to RSP. Multiple matches cannot occur; if forced, the lowest index wins.
  - Miss with an invalid entry: install in the lowest invalid index (set valid, write tag), rsp_hit=0, rsp_buf=index, ref_buf_numbr<=index, miss_cnt++, go to RSP. new_buf_req is not asserted.
  - Miss with all valid: miss_cnt++, go to REPL.
- REPL: new_buf_req=1 for exactly this one cycle; go to WAIT.
- WAIT: new_buf_req=0.
  - Sample buf_num_replc as v.
  - Overwrite tag[v] with the captured tag; valid stays 1.
  - rsp_hit=0, rsp_buf=v, ref_buf_numbr<=v, go to RSP.
- RSP:
  - rsp_vld=1 and held; rsp_hit/rsp_buf stable until rsp_rdy.
  - On rsp_rdy: rsp_vld<=0, go to IDLE.
  - req_rdy=0 in every state except IDLE.
- Latency from the accept edge (cycle 0):
  - Hit / free-entry miss: rsp_vld high in cycle 2.
  - Full miss: new_buf_req high in cycle 2, rsp_vld high in cycle 4.
  - Back-to-back throughput is one transaction per 3 (or 5) cycles minimum.
- ref_buf_numbr holds its value between transactions; it is never changed by flush.
- Counters saturate at 2^CNT_W-1 (no wrap). They are cleared only by reset, not by flush.
- flush while not IDLE: ignored; it must be held until IDLE to take effect.
- A request with the same tag as an entry just installed: hit on the next transaction.

Test Plan:
- Reset, then 4 requests with tags 0x10,0x20,0x30,0x40 -> 4 misses in buf 0,1,2,3; new_buf_req never asserted; miss_cnt=4; ref_buf_numbr=3.
- Request tag 0x20 after the above -> rsp_hit=1, rsp_buf=1, ref_buf_numbr=1, rsp_vld 2 cycles after accept; hit_cnt=1.
- Request tag 0x55 with the directory full and LFU model returning 2 -> new_buf_req high exactly 1 cycle at accept+2; rsp_hit=0, rsp_buf=2 at accept+4; a following request for 0x55 hits buf 2 and 0x30 misses.
- Hold rsp_rdy=0 for 5 cycles on a hit -> rsp_vld, rsp_hit, rsp_buf stable; req_rdy=0; a new req_vld is not accepted until the cycle after the rsp handshake.
- flush in IDLE with req_vld=1 -> req_rdy=0, all entries invalid; next request for 0x10 misses into buf 0 without new_buf_req; hit_cnt/miss_cnt unchanged by flush.
- Assert rst_n=0 during WAIT -> all outputs at reset values immediately; after release, request 0x10 misses into buf 0 with no response from the aborted transaction; force miss_cnt to max-1 with CNT_W=2 and observe saturation at 3.

Source files
------------

// File: rtl/buf_alloc_ctrl_if.sv
// Request/response, LFU-selector and statistics signals of buf_alloc_ctrl.
// slave is the controller side, master is the client/selector side.
interface buf_alloc_ctrl_if #(
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
);
    logic             req_vld;
    logic [TAG_W-1:0] req_tag;
    logic             req_rdy;
    logic             flush;
    logic             rsp_vld;
    logic             rsp_rdy;
    logic             rsp_hit;
    logic [1:0]       rsp_buf;
    logic             new_buf_req;
    logic [1:0]       ref_buf_numbr;
    logic [1:0]       buf_num_replc;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport slave (
        input  req_vld, req_tag, flush, rsp_rdy, buf_num_replc,
        output req_rdy, rsp_vld, rsp_hit, rsp_buf, new_buf_req,
               ref_buf_numbr, hit_cnt, miss_cnt
    );

    modport master (
        output req_vld, req_tag, flush, rsp_rdy, buf_num_replc,
        input  req_rdy, rsp_vld, rsp_hit, rsp_buf, new_buf_req,
               ref_buf_numbr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/buf_alloc_ctrl.sv
// 4-entry tag directory resolving lookups to a buffer number; on a full miss
// the victim comes from the external LFU selector.
module buf_alloc_ctrl #(
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    buf_alloc_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CMP, REPL, WAIT, RSP} state_t;

    state_t           state_q;
    logic [TAG_W-1:0] cap_tag_q;
    logic [TAG_W-1:0] tag_q [4];
    logic [3:0]       valid_q;
    logic             rsp_vld_q;
    logic             rsp_hit_q;
    logic [1:0]       rsp_buf_q;
    logic             new_buf_req_q;
    logic [1:0]       ref_q;
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;
    logic [CNT_W-1:0] hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_d;

    logic       hit_any;
    logic [1:0] hit_idx;
    logic       free_any;
    logic [1:0] free_idx;

    // Lowest index wins for both matching and free-entry selection.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (valid_q[i] && (tag_q[i] == cap_tag_q) && !hit_any) begin
                hit_any = 1'b1;
                hit_idx = 2'(i);
            end
            if (!valid_q[i] && !free_any) begin
                free_any = 1'b1;
                free_idx = 2'(i);
            end
        end
    end

    always_comb begin
        hit_cnt_d  = (hit_cnt_q  == '1) ? hit_cnt_q  : hit_cnt_q  + 1'b1;
        miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cap_tag_q     <= '0;
            valid_q       <= '0;
            rsp_vld_q     <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_buf_q     <= '0;
            new_buf_req_q <= 1'b0;
            ref_q         <= '0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            for (int unsigned i = 0; i < 4; i++) tag_q[i] <= '0;
        end else begin
            new_buf_req_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.flush) begin
                        valid_q <= '0;
                    end else if (bus.req_vld) begin
                        cap_tag_q <= bus.req_tag;
                        state_q   <= CMP;
                    end
                end
                CMP: begin
                    if (hit_any) begin
                        rsp_hit_q <= 1'b1;
                        rsp_buf_q <= hit_idx;
                        ref_q     <= hit_idx;
                        hit_cnt_q <= hit_cnt_d;
                        rsp_vld_q <= 1'b1;
                        state_q   <= RSP;
                    end else if (free_any) begin
                        valid_q[free_idx] <= 1'b1;
                        tag_q[free_idx]   <= cap_tag_q;
                        rsp_hit_q         <= 1'b0;
                        rsp_buf_q         <= free_idx;
                        ref_q             <= free_idx;
                        miss_cnt_q        <= miss_cnt_d;
                        rsp_vld_q         <= 1'b1;
                        state_q           <= RSP;
                    end else begin
                        // Raised on entry so it is high for the whole REPL cycle only.
                        miss_cnt_q    <= miss_cnt_d;
                        new_buf_req_q <= 1'b1;
                        state_q       <= REPL;
                    end
                end
                REPL: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    tag_q[bus.buf_num_replc] <= cap_tag_q;
                    rsp_hit_q <= 1'b0;
                    rsp_buf_q <= bus.buf_num_replc;
                    ref_q     <= bus.buf_num_replc;
                    rsp_vld_q <= 1'b1;
                    state_q   <= RSP;
                end
                RSP: begin
                    if (bus.rsp_rdy) begin
                        rsp_vld_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_rdy       = (state_q == IDLE) && !bus.flush;
    assign bus.rsp_vld       = rsp_vld_q;
    assign bus.rsp_hit       = rsp_hit_q;
    assign bus.rsp_buf       = rsp_buf_q;
    assign bus.new_buf_req   = new_buf_req_q;
    assign bus.ref_buf_numbr = ref_q;
    assign bus.hit_cnt       = hit_cnt_q;
    assign bus.miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_buf_alloc_ctrl.sv
// Directed bench for buf_alloc_ctrl: fill, hit, LFU replacement, response
// stall, flush, mid-transaction reset and counter saturation (CNT_W=2 copy).
module tb_buf_alloc_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    buf_alloc_ctrl_if #(.TAG_W(8), .CNT_W(16)) a ();
    buf_alloc_ctrl_if #(.TAG_W(8), .CNT_W(2))  s ();

    buf_alloc_ctrl #(.TAG_W(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a)
    );

    buf_alloc_ctrl #(.TAG_W(8), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on the main DUT starting in an IDLE cycle; cycle 0 is the
    // accept cycle. Returns response fields, response cycle and new_buf_req info.
    task automatic run_txn(input logic [7:0] tag, output logic hit, output logic [1:0] bnum,
                           output int lat, output int nbr_n, output int nbr_at);
        bit done;
        done = 1'b0;
        lat = -1; nbr_n = 0; nbr_at = -1; hit = 1'b0; bnum = '0;
        a.req_vld = 1'b1; a.req_tag = tag; a.rsp_rdy = 1'b1;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (a.req_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL txn_accept tag=%h: req_rdy=%b expected 1", tag, a.req_rdy);
                end
            end
            if (a.new_buf_req === 1'b1) begin
                nbr_n++;
                if (nbr_at < 0) nbr_at = c;
            end
            if (a.rsp_vld === 1'b1) begin
                lat = c; hit = a.rsp_hit; bnum = a.rsp_buf; done = 1'b1;
            end
            tick();
            if (c == 0) a.req_vld = 1'b0;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL txn_timeout tag=%h: no rsp_vld within 16 cycles", tag);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({a.rsp_vld, a.rsp_hit, a.rsp_buf, a.new_buf_req, a.ref_buf_numbr} !== 7'b0 ||
            a.hit_cnt !== 16'd0 || a.miss_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: vld=%b hit=%b buf=%0d nbr=%b ref=%0d hc=%0d mc=%0d expected all 0",
                     a.rsp_vld, a.rsp_hit, a.rsp_buf, a.new_buf_req, a.ref_buf_numbr, a.hit_cnt, a.miss_cnt);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (a.req_rdy !== 1'b1 || a.rsp_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: req_rdy=%b rsp_vld=%b expected 1/0", a.req_rdy, a.rsp_vld);
        end
        tick();
    endtask

    task automatic test_fill();
        logic [7:0] tags [4];
        logic hit; logic [1:0] b; int lat, nn, na;
        tags = '{8'h10, 8'h20, 8'h30, 8'h40};
        for (int i = 0; i < 4; i++) begin
            run_txn(tags[i], hit, b, lat, nn, na);
            checks++;
            if (hit !== 1'b0 || b !== 2'(i) || lat != 2 || nn != 0) begin
                errors++;
                $display("FAIL fill_%0d: hit=%b buf=%0d lat=%0d nbr=%0d expected 0/%0d/2/0", i, hit, b, lat, nn, i);
            end
        end
        @(negedge clk);
        checks++;
        if (a.miss_cnt !== 16'd4 || a.hit_cnt !== 16'd0 || a.ref_buf_numbr !== 2'd3) begin
            errors++;
            $display("FAIL fill_stats: miss=%0d hit=%0d ref=%0d expected 4/0/3", a.miss_cnt, a.hit_cnt, a.ref_buf_numbr);
        end
        tick();
    endtask

    task automatic test_hit();
        logic hit; logic [1:0] b; int lat, nn, na;
        run_txn(8'h20, hit, b, lat, nn, na);
        checks++;
        if (hit !== 1'b1 || b !== 2'd1 || lat != 2 || nn != 0) begin
            errors++;
            $display("FAIL hit_20: hit=%b buf=%0d lat=%0d nbr=%0d expected 1/1/2/0", hit, b, lat, nn);
        end
        @(negedge clk);
        checks++;
        if (a.ref_buf_numbr !== 2'd1 || a.hit_cnt !== 16'd1 || a.miss_cnt !== 16'd4) begin
            errors++;
            $display("FAIL hit_stats: ref=%0d hit=%0d miss=%0d expected 1/1/4", a.ref_buf_numbr, a.hit_cnt, a.miss_cnt);
        end
        tick();
    endtask

    task automatic test_replace();
        logic hit; logic [1:0] b; int lat, nn, na;
        a.buf_num_replc = 2'd2;
        run_txn(8'h55, hit, b, lat, nn, na);
        checks++;
        if (nn != 1 || na != 2 || lat != 4 || hit !== 1'b0 || b !== 2'd2) begin
            errors++;
            $display("FAIL repl_55: nbr_cycles=%0d nbr_at=%0d lat=%0d hit=%b buf=%0d expected 1/2/4/0/2", nn, na, lat, hit, b);
        end
        @(negedge clk);
        checks++;
        if (a.ref_buf_numbr !== 2'd2 || a.miss_cnt !== 16'd5) begin
            errors++;
            $display("FAIL repl_stats: ref=%0d miss=%0d expected 2/5", a.ref_buf_numbr, a.miss_cnt);
        end
        tick();
        run_txn(8'h55, hit, b, lat, nn, na);
        checks++;
        if (hit !== 1'b1 || b !== 2'd2 || lat != 2 || nn != 0) begin
            errors++;
            $display("FAIL repl_rehit_55: hit=%b buf=%0d lat=%0d nbr=%0d expected 1/2/2/0", hit, b, lat, nn);
        end
        a.buf_num_replc = 2'd0;
        run_txn(8'h30, hit, b, lat, nn, na);
        checks++;
        if (hit !== 1'b0 || b !== 2'd0 || lat != 4 || nn != 1) begin
            errors++;
            $display("FAIL repl_evicted_30: hit=%b buf=%0d lat=%0d nbr=%0d expected 0/0/4/1", hit, b, lat, nn);
        end
        @(negedge clk);
        checks++;
        if (a.hit_cnt !== 16'd2 || a.miss_cnt !== 16'd6 || a.ref_buf_numbr !== 2'd0) begin
            errors++;
            $display("FAIL repl_final: hit=%0d miss=%0d ref=%0d expected 2/6/0", a.hit_cnt, a.miss_cnt, a.ref_buf_numbr);
        end
        tick();
    endtask

    task automatic test_rsp_stall();
        a.rsp_rdy = 1'b0; a.req_vld = 1'b1; a.req_tag = 8'h20;
        tick();
        a.req_tag = 8'h40;
        @(negedge clk);
        checks++;
        if (a.req_rdy !== 1'b0 || a.rsp_vld !== 1'b0) begin
            errors++;
            $display("FAIL stall_cmp: req_rdy=%b rsp_vld=%b expected 0/0", a.req_rdy, a.rsp_vld);
        end
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (a.rsp_vld !== 1'b1 || a.rsp_hit !== 1'b1 || a.rsp_buf !== 2'd1 || a.req_rdy !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d: vld=%b hit=%b buf=%0d req_rdy=%b expected 1/1/1/0",
                         k, a.rsp_vld, a.rsp_hit, a.rsp_buf, a.req_rdy);
            end
            tick();
        end
        a.rsp_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (a.rsp_vld !== 1'b1 || a.req_rdy !== 1'b0 || a.ref_buf_numbr !== 2'd1) begin
            errors++;
            $display("FAIL stall_release: vld=%b req_rdy=%b ref=%0d expected 1/0/1", a.rsp_vld, a.req_rdy, a.ref_buf_numbr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (a.rsp_vld !== 1'b0 || a.req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL stall_idle: vld=%b req_rdy=%b expected 0/1", a.rsp_vld, a.req_rdy);
        end
        tick();
        a.req_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (a.req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL stall_next_accept: req_rdy=%b expected 0", a.req_rdy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (a.rsp_vld !== 1'b1 || a.rsp_hit !== 1'b1 || a.rsp_buf !== 2'd3) begin
            errors++;
            $display("FAIL stall_next_rsp: vld=%b hit=%b buf=%0d expected 1/1/3", a.rsp_vld, a.rsp_hit, a.rsp_buf);
        end
        tick();
        @(negedge clk);
        checks++;
        if (a.hit_cnt !== 16'd4 || a.ref_buf_numbr !== 2'd3 || a.rsp_vld !== 1'b0) begin
            errors++;
            $display("FAIL stall_stats: hit=%0d ref=%0d vld=%b expected 4/3/0", a.hit_cnt, a.ref_buf_numbr, a.rsp_vld);
        end
        tick();
    endtask

    task automatic test_flush();
        logic hit; logic [1:0] b; int lat, nn, na;
        a.flush = 1'b1; a.req_vld = 1'b1; a.req_tag = 8'h10;
        @(negedge clk);
        checks++;
        if (a.req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL flush_rdy: req_rdy=%b expected 0", a.req_rdy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (a.req_rdy !== 1'b0 || a.rsp_vld !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_accept: req_rdy=%b rsp_vld=%b expected 0/0", a.req_rdy, a.rsp_vld);
        end
        a.flush = 1'b0; a.req_vld = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (a.hit_cnt !== 16'd4 || a.miss_cnt !== 16'd6 || a.ref_buf_numbr !== 2'd3) begin
            errors++;
            $display("FAIL flush_stats: hit=%0d miss=%0d ref=%0d expected 4/6/3", a.hit_cnt, a.miss_cnt, a.ref_buf_numbr);
        end
        tick();
        run_txn(8'h10, hit, b, lat, nn, na);
        checks++;
        if (hit !== 1'b0 || b !== 2'd0 || lat != 2 || nn != 0) begin
            errors++;
            $display("FAIL flush_miss_10: hit=%b buf=%0d lat=%0d nbr=%0d expected 0/0/2/0", hit, b, lat, nn);
        end
        run_txn(8'h20, hit, b, lat, nn, na);
        checks++;
        if (hit !== 1'b0 || b !== 2'd1 || nn != 0) begin
            errors++;
            $display("FAIL flush_miss_20: hit=%b buf=%0d nbr=%0d expected 0/1/0", hit, b, nn);
        end
        @(negedge clk);
        checks++;
        if (a.miss_cnt !== 16'd8 || a.hit_cnt !== 16'd4) begin
            errors++;
            $display("FAIL flush_after: miss=%0d hit=%0d expected 8/4", a.miss_cnt, a.hit_cnt);
        end
        tick();
    endtask

    task automatic test_reset_wait();
        logic hit; logic [1:0] b; int lat, nn, na;
        run_txn(8'h30, hit, b, lat, nn, na);
        run_txn(8'h40, hit, b, lat, nn, na);
        a.buf_num_replc = 2'd1;
        a.req_vld = 1'b1; a.req_tag = 8'h99;
        tick();
        a.req_vld = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (a.new_buf_req !== 1'b1) begin
            errors++;
            $display("FAIL rstw_repl: new_buf_req=%b expected 1", a.new_buf_req);
        end
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a.rsp_vld, a.rsp_hit, a.rsp_buf, a.new_buf_req, a.ref_buf_numbr} !== 7'b0 ||
            a.hit_cnt !== 16'd0 || a.miss_cnt !== 16'd0 || a.req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rstw_async: vld=%b hit=%b buf=%0d nbr=%b ref=%0d hc=%0d mc=%0d rdy=%b expected 0s, rdy 1",
                     a.rsp_vld, a.rsp_hit, a.rsp_buf, a.new_buf_req, a.ref_buf_numbr, a.hit_cnt, a.miss_cnt, a.req_rdy);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (a.rsp_vld !== 1'b0) begin
                errors++;
                $display("FAIL rstw_no_rsp_%0d: rsp_vld=%b expected 0", k, a.rsp_vld);
            end
            tick();
        end
        run_txn(8'h10, hit, b, lat, nn, na);
        checks++;
        if (hit !== 1'b0 || b !== 2'd0 || lat != 2 || nn != 0) begin
            errors++;
            $display("FAIL rstw_miss_10: hit=%b buf=%0d lat=%0d nbr=%0d expected 0/0/2/0", hit, b, lat, nn);
        end
        @(negedge clk);
        checks++;
        if (a.miss_cnt !== 16'd1 || a.hit_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rstw_stats: miss=%0d hit=%0d expected 1/0", a.miss_cnt, a.hit_cnt);
        end
        tick();
    endtask

    task automatic test_saturate();
        int exp_cnt;
        bit got;
        for (int i = 0; i < 5; i++) begin
            s.req_vld = 1'b1; s.req_tag = 8'(i + 1);
            tick();
            s.req_vld = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 12 && !got; c++) begin
                @(negedge clk);
                if (s.rsp_vld === 1'b1) got = 1'b1;
                tick();
            end
            exp_cnt = (i + 1 > 3) ? 3 : i + 1;
            @(negedge clk);
            checks++;
            if (!got || s.miss_cnt !== 2'(exp_cnt)) begin
                errors++;
                $display("FAIL sat_miss_%0d: got_rsp=%b miss_cnt=%0d expected 1/%0d", i, got, s.miss_cnt, exp_cnt);
            end
            tick();
        end
    endtask

    initial begin
        a.req_vld = 1'b0; a.req_tag = '0; a.flush = 1'b0; a.rsp_rdy = 1'b1; a.buf_num_replc = '0;
        s.req_vld = 1'b0; s.req_tag = '0; s.flush = 1'b0; s.rsp_rdy = 1'b1; s.buf_num_replc = '0;
        tick();
        test_reset();
        test_fill();
        test_hit();
        test_replace();
        test_rsp_stall();
        test_flush();
        test_reset_wait();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
